// File: rtl/bl_zone_spi_tx.sv
// bl_zone_spi_tx: double-buffered backlight zone store streamed over SPI with a trailing latch pulse.
module bl_zone_spi_tx #(
   parameter int NUM_ZONES = 384,
   parameter int CLK_DIV   = 4
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [8:0]  wr_index,
   input  logic [15:0] wr_light,
   input  logic        frame_done,
   output logic        busy,
   output logic        overrun,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic        bl_lat
);
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] HALF    = CW'(CLK_DIV);
   localparam logic [CW-1:0] LAT_END = CW'(CLK_DIV - 1);
   localparam logic [8:0]    LAST_Z  = 9'(NUM_ZONES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

   state_t        state_q, state_d;
   logic          bank_q, bank_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    zone_q, zone_d;
   logic          overrun_q;
   logic [15:0]   mem_q [0:1023];
   logic [15:0]   rdata_q;
   logic          bit_end, word_end, rd_en;
   logic [9:0]    rd_addr;

   // The read register holds the word on the wire; the next word is read on the
   // last cycle of the current one so it lands exactly at the word boundary.
   assign bit_end  = state_q == SHIFT && cnt_q == BIT_END;
   assign word_end = bit_end && bit_q == 4'hF;
   assign rd_en    = state_q == LOAD || (word_end && zone_q != LAST_Z);
   assign rd_addr  = {bank_q, state_q == LOAD ? 9'd0 : zone_q + 9'd1};

   always_ff @(posedge pclk) begin
      if (wr_en && {1'b0, wr_index} < 10'(NUM_ZONES)) mem_q[{~bank_q, wr_index}] <= wr_light;
      if (rd_en) rdata_q <= mem_q[rd_addr];
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bank_q    <= 1'b0;
         cnt_q     <= '0;
         bit_q     <= '0;
         zone_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bank_q    <= bank_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         zone_q    <= zone_d;
         overrun_q <= frame_done && state_q != IDLE;
      end
   end

   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      zone_d  = zone_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            zone_d = '0;
            if (frame_done) begin
               state_d = LOAD;
               bank_d  = ~bank_q;
            end
         end
         LOAD: state_d = SHIFT;
         SHIFT: begin
            cnt_d  = bit_end ? '0 : cnt_q + CW'(1);
            bit_d  = bit_end ? bit_q + 4'd1 : bit_q;
            zone_d = word_end && zone_q != LAST_Z ? zone_q + 9'd1 : zone_q;
            if (word_end && zone_q == LAST_Z) state_d = LATCH;
         end
         LATCH: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAT_END) state_d = IDLE;
         end
      endcase
   end

   assign busy     = state_q != IDLE;
   assign overrun  = overrun_q;
   assign spi_sclk = state_q == SHIFT && cnt_q >= HALF;
   assign spi_cs_n = state_q != SHIFT;
   assign spi_mosi = state_q == SHIFT && rdata_q[~bit_q];
   assign bl_lat   = state_q == LATCH;
endmodule

// File: tb/tb_bl_zone_spi_tx.sv
// tb_bl_zone_spi_tx: directed + random frames checked against a bank-array model and a serial slave.
module tb_bl_zone_spi_tx;
   localparam int N = 4;
   localparam int D = 2;

   logic        pclk = 0, rst_n = 0, wr_en = 0, frame_done = 0;
   logic [8:0]  wr_index = 0;
   logic [15:0] wr_light = 0;
   logic        busy, overrun, spi_sclk, spi_mosi, spi_cs_n, bl_lat;

   int          total = 0, bad = 0;
   logic [15:0] mb [2][N];
   int          bk = 0;
   logic [15:0] exp_w [N];
   logic [15:0] got_w [N];
   int          cs_cnt = 0, rises = 0, lat_cnt = 0, lat_pul = 0, busy_cnt = 0, ovr_cnt = 0, misal = 0, mosi_bad = 0;
   logic        sclk_p = 0, cs_p = 1, lat_p = 0;
   logic        bits [$];
   int          s_cs, s_rises, s_lat, s_pul, s_busy, s_ovr, nb, n_rej;

   always #5 pclk = ~pclk;

   bl_zone_spi_tx #(.NUM_ZONES(N), .CLK_DIV(D)) dut (
      .pclk(pclk), .rst_n(rst_n), .wr_en(wr_en), .wr_index(wr_index), .wr_light(wr_light),
      .frame_done(frame_done), .busy(busy), .overrun(overrun), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .bl_lat(bl_lat)
   );

   // Slave side: samples MOSI on SCLK rise and tallies link activity.
   always @(negedge pclk) begin
      if (!spi_cs_n) cs_cnt <= cs_cnt + 1;
      if (spi_sclk && !sclk_p && !spi_cs_n) begin
         rises <= rises + 1;
         bits.push_back(spi_mosi);
      end
      if (bl_lat) lat_cnt <= lat_cnt + 1;
      if (bl_lat && !lat_p) lat_pul <= lat_pul + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (rst_n && spi_cs_n && !cs_p && !bl_lat) misal <= misal + 1;
      if (spi_cs_n && spi_mosi) mosi_bad <= mosi_bad + 1;
      sclk_p <= spi_sclk;
      cs_p   <= spi_cs_n;
      lat_p  <= bl_lat;
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic wr(input int idx, input logic [15:0] v);
      @(negedge pclk);
      wr_en = 1; wr_index = 9'(idx); wr_light = v;
      if (idx < N) mb[bk ^ 1][idx] = v;
      @(negedge pclk);
      wr_en = 0;
   endtask

   task automatic start_frame(input bit w, input int idx, input logic [15:0] v);
      s_cs = cs_cnt; s_rises = rises; s_lat = lat_cnt; s_pul = lat_pul;
      s_busy = busy_cnt; s_ovr = ovr_cnt; nb = bits.size(); n_rej = 0;
      @(negedge pclk);
      frame_done = 1;
      if (w) begin
         wr_en = 1; wr_index = 9'(idx); wr_light = v;
         if (idx < N) mb[bk ^ 1][idx] = v;
      end
      bk ^= 1;
      for (int i = 0; i < N; i++) exp_w[i] = mb[bk][i];
      @(negedge pclk);
      frame_done = 0; wr_en = 0;
      chk("busy_rise", busy, 1);
      chk("cs_high_in_load", spi_cs_n, 1);
      @(negedge pclk);
      chk("cs_fall", spi_cs_n, 0);
      chk("sclk_first_low", spi_sclk, 0);
      chk("mosi_first_msb", spi_mosi, exp_w[0][15]);
      repeat (D - 1) @(negedge pclk);
      chk("sclk_before_rise", spi_sclk, 0);
      @(negedge pclk);
      chk("sclk_first_rise", spi_sclk, 1);
   endtask

   task automatic reject();
      @(negedge pclk);
      frame_done = 1;
      @(negedge pclk);
      frame_done = 0;
      n_rej++;
      chk("overrun_pulse", overrun, 1);
      @(negedge pclk);
      chk("overrun_single", overrun, 0);
   endtask

   task automatic finish_frame();
      bit ok;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge pclk);
         ok = !busy;
      end
      chk("done_timeout", ok, 1);
      chk("cs_low_cycles", cs_cnt - s_cs, 32 * D * N);
      chk("sclk_rises", rises - s_rises, 16 * N);
      chk("lat_cycles", lat_cnt - s_lat, D);
      chk("lat_pulses", lat_pul - s_pul, 1);
      chk("busy_cycles", busy_cnt - s_busy, 1 + 32 * D * N + D);
      chk("overrun_count", ovr_cnt - s_ovr, n_rej);
      chk("cs_lat_align", misal, 0);
      chk("mosi_idle_zero", mosi_bad, 0);
      chk("bit_count", bits.size() - nb, 16 * N);
      if (bits.size() >= nb + 16 * N)
         for (int w = 0; w < N; w++) begin
            got_w[w] = '0;
            for (int b = 0; b < 16; b++) got_w[w] = {got_w[w][14:0], bits[nb + 16 * w + b]};
            chk($sformatf("word%0d", w), got_w[w], exp_w[w]);
         end
   endtask

   initial begin
      bit ok;
      for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mb[b][i] = '0;
      // Reset held: inputs wiggle, outputs must not.
      repeat (3) begin
         @(negedge pclk);
         frame_done = ~frame_done; wr_en = 1; wr_index = 9'h1FF;
         chk("rst_hold", {busy, overrun, spi_sclk, spi_mosi, spi_cs_n, bl_lat}, 6'b000010);
      end
      @(negedge pclk);
      frame_done = 0; wr_en = 0;
      chk("rst_hold_last", {busy, overrun, spi_sclk, spi_mosi, spi_cs_n, bl_lat}, 6'b000010);
      rst_n = 1;
      @(negedge pclk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cs", spi_cs_n, 1);

      // Basic frame
      wr(0, 16'hA5C3); wr(1, 16'h0001); wr(2, 16'h8000); wr(3, 16'hFFFF);
      start_frame(0, 0, 0);
      finish_frame();

      // Double buffer: back-bank writes during the transfer
      start_frame(0, 0, 0);
      wr(0, 16'h1111); wr(1, 16'h2222); wr(2, 16'h3333); wr(3, 16'h4444);
      finish_frame();
      start_frame(0, 0, 0);
      finish_frame();
      chk("dbuf_word3", got_w[3], 16'h4444);

      // Overrun
      wr(0, 16'h0F0F); wr(1, 16'hF0F0); wr(2, 16'h1234); wr(3, 16'h8765);
      start_frame(0, 0, 0);
      repeat (45) @(negedge pclk);
      reject();
      finish_frame();
      s_busy = busy_cnt;
      repeat (30) @(negedge pclk);
      chk("no_extra_transfer", busy_cnt - s_busy, 0);

      // Out-of-range write and write coinciding with frame_done
      wr(4, 16'hDEAD);
      start_frame(1, 2, 16'h5A5A);
      finish_frame();
      chk("simul_word2", got_w[2], 16'h5A5A);

      // Reset in the middle of a transfer
      start_frame(0, 0, 0);
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge pclk);
         ok = bits.size() >= nb + 21;
      end
      chk("bit20_timeout", ok, 1);
      @(posedge pclk);
      #1 rst_n = 0;
      #1 chk("rst_async", {busy, overrun, spi_sclk, spi_mosi, spi_cs_n, bl_lat}, 6'b000010);
      repeat (5) @(negedge pclk);
      chk("rst_no_lat", lat_pul - s_pul, 0);
      chk("rst_still", {busy, overrun, spi_sclk, spi_mosi, spi_cs_n, bl_lat}, 6'b000010);
      rst_n = 1;
      bk = 0;
      @(negedge pclk);
      start_frame(0, 0, 0);
      finish_frame();

      // Random traffic, including out-of-range indices and writes mid-transfer
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 6; k++) wr($urandom_range(0, 6), 16'($urandom));
         start_frame($urandom_range(0, 1) == 1, $urandom_range(0, 5), 16'($urandom));
         for (int k = 0; k < 4; k++) wr($urandom_range(0, 6), 16'($urandom));
         finish_frame();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
